// File: rtl/keypad_scan_if.sv
// Signal bundle between the keypad scanner and its neighbours: keypad matrix
// lines on one side, debounced key state and press events on the other.
interface keypad_scan_if;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] btn;
    logic [15:0] btn_pulse;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        frame_tick;

    modport master (
        input  col,
        output row, btn, btn_pulse, key_valid, key_code, frame_tick
    );

    modport slave (
        output col,
        input  row, btn, btn_pulse, key_valid, key_code, frame_tick
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, column capture into a 16-bit frame,
// per-key frame-count debounce and one-shot press events.
module keypad_scan #(
    parameter int CLK_DIV        = 2500,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]       col_p0;
    logic [3:0]       col_p1;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_sel;
    logic [1:0]       row_next;
    logic [15:0]      raw;
    logic             sample;
    logic [CNT_W-1:0] cnt     [16];
    logic [CNT_W-1:0] cnt_nxt [16];
    logic [15:0]      btn_nxt;
    logic [15:0]      rise;

    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign sample   = (div_cnt == DIV_LAST);
    assign row_next = row_sel + 2'd1;

    // Stage 0: column synchronizer, row scan and frame capture.
    // The synchronizer idles at all-ones (no key) so nothing is seen pressed out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_p0        <= 4'hF;
            col_p1        <= 4'hF;
            div_cnt       <= '0;
            row_sel       <= 2'd0;
            raw           <= '0;
            kp.row        <= 4'b1110;
            kp.frame_tick <= 1'b0;
        end else begin
            col_p0        <= kp.col;
            col_p1        <= col_p0;
            kp.frame_tick <= sample && (row_sel == 2'd3);
            if (sample) begin
                div_cnt                   <= '0;
                raw[{row_sel, 2'b00} +: 4] <= ~col_p1;
                row_sel                   <= row_next;
                kp.row                    <= ~(4'b0001 << row_next);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        btn_nxt = kp.btn;
        for (int k = 0; k < 16; k++) begin
            cnt_nxt[k] = cnt[k];
            if (raw[k] == kp.btn[k]) begin
                cnt_nxt[k] = '0;
            end else if (cnt[k] == CNT_LAST) begin
                btn_nxt[k] = raw[k];
                cnt_nxt[k] = '0;
            end else begin
                cnt_nxt[k] = cnt[k] + 1'b1;
            end
        end
        rise = btn_nxt & ~kp.btn;
    end

    // Stage 1: debounce and press-event registers, updated once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            kp.btn       <= '0;
            kp.btn_pulse <= '0;
            kp.key_valid <= 1'b0;
            kp.key_code  <= 4'd0;
            for (int k = 0; k < 16; k++) cnt[k] <= '0;
        end else begin
            kp.btn_pulse <= '0;
            kp.key_valid <= 1'b0;
            if (kp.frame_tick) begin
                kp.btn       <= btn_nxt;
                kp.btn_pulse <= rise;
                kp.key_valid <= |rise;
                if (|rise) kp.key_code <= lowest_index(rise);
                for (int k = 0; k < 16; k++) cnt[k] <= cnt_nxt[k];
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed bench for keypad_scan against a frame-level model of
// key presses, debounce and press events.
module tb_keypad_scan;
    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;
    localparam int FRAME   = 4 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    keypad_scan_if kp ();

    keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its column low while its row is driven low.
    logic [15:0] pressed = '0;
    always_comb begin
        kp.col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.row[r] && pressed[r*4+c]) kp.col[c] = 1'b0;
    end

    int          total = 0;
    int          bad   = 0;
    int          t     = 0;
    logic [15:0] m_btn, m_pulse, m_raw;
    logic        m_valid;
    logic [3:0]  m_code;
    int          m_run [16];
    logic [15:0] plan [$];
    int          pulse_seen;
    int          pulse_t;
    logic [15:0] last_pulse;
    logic [3:0]  last_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t       = 0;
        m_btn   = '0;
        m_pulse = '0;
        m_raw   = '0;
        m_valid = 1'b0;
        m_code  = 4'd0;
        for (int k = 0; k < 16; k++) m_run[k] = 0;
    endtask

    // One completed frame: a key flips once its raw level has disagreed for DEB frames in a row.
    task automatic model_frame();
        logic [15:0] nb;
        bit          found;
        nb = m_btn;
        for (int k = 0; k < 16; k++) begin
            if (m_raw[k] != m_btn[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    nb[k]    = m_raw[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_pulse = nb & ~m_btn;
        m_btn   = nb;
        m_valid = (m_pulse != 0);
        found   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!found && m_pulse[k]) begin
                m_code = 4'(k);
                found  = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] er;
        logic       ef;
        er = ~(4'b0001 << ((t / CLK_DIV) % 4));
        ef = (t > 0) && (t % FRAME == 0);
        chk("row", kp.row, er);
        chk("frame_tick", kp.frame_tick, ef);
        chk("btn", kp.btn, m_btn);
        chk("btn_pulse", kp.btn_pulse, m_pulse);
        chk("key_valid", kp.key_valid, m_valid);
        chk("key_code", kp.key_code, m_code);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        if (t % FRAME == 1 && t > FRAME) begin
            model_frame();
        end else begin
            m_pulse = '0;
            m_valid = 1'b0;
        end
        check_outputs();
        if (kp.btn_pulse != 0) begin
            pulse_seen++;
            pulse_t    = t;
            last_pulse = kp.btn_pulse;
            last_code  = kp.key_code;
        end
        if (t % FRAME == 1) begin
            if (plan.size() > 0) pressed = plan.pop_front();
            m_raw = pressed;
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
    endtask

    task automatic clear_obs();
        pulse_seen = 0;
        pulse_t    = -1;
        last_pulse = '0;
        last_code  = 4'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_obs();
        do_reset();
        run_frames(2);

        // Key 6 held: one pulse, then none for the next ten frames.
        clear_obs();
        repeat (14) plan.push_back(16'h0040);
        run_frames(14);
        chk("k6_pulse_count", pulse_seen, 1);
        chk("k6_pulse_value", last_pulse, 16'h0040);
        chk("k6_code", last_code, 6);

        // Release: btn falls, no pulse.
        clear_obs();
        repeat (5) plan.push_back(16'h0000);
        run_frames(5);
        chk("release_pulse_count", pulse_seen, 0);
        chk("release_btn", kp.btn, 16'h0000);

        // Bounce shorter than the debounce window.
        clear_obs();
        foreach (plan[i]) plan.delete(i);
        plan.push_back(16'h0040); plan.push_back(16'h0040); plan.push_back(16'h0000);
        plan.push_back(16'h0040); plan.push_back(16'h0040);
        repeat (3) plan.push_back(16'h0000);
        run_frames(8);
        chk("bounce_pulse_count", pulse_seen, 0);
        chk("bounce_btn", kp.btn, 16'h0000);

        // Keys 2 and 10 together.
        clear_obs();
        repeat (4) plan.push_back(16'h0404);
        repeat (4) plan.push_back(16'h0000);
        run_frames(8);
        chk("dual_pulse_count", pulse_seen, 1);
        chk("dual_pulse_value", last_pulse, 16'h0404);
        chk("dual_code", last_code, 2);

        // Random press/hold/gap sequences.
        begin
            int frames;
            frames = 0;
            while (frames < 60) begin
                logic [15:0] v;
                int          hold;
                int          gap;
                v = 16'(1) << $urandom_range(0, 15);
                if ($urandom_range(0, 2) == 0) v = v | (16'(1) << $urandom_range(0, 15));
                hold = $urandom_range(1, 6);
                gap  = $urandom_range(1, 4);
                repeat (hold) plan.push_back(v);
                repeat (gap) plan.push_back(16'h0000);
                frames += hold + gap;
            end
            run_frames(frames + 4);
        end

        // Reset mid-row-2 with key 6 debounced high and key 9 two frames into debounce.
        repeat (4) plan.push_back(16'h0040);
        repeat (2) plan.push_back(16'h0240);
        run_frames(6);
        step();
        while (t % FRAME != 10) step();
        chk("pre_reset_btn6", kp.btn[6], 1'b1);
        clear_obs();
        repeat (5) plan.push_back(16'h0200);
        do_reset();
        run_frames(5);
        chk("k9_pulse_count", pulse_seen, 1);
        chk("k9_pulse_value", last_pulse, 16'h0200);
        chk("k9_code", last_code, 9);
        chk("k9_pulse_time", pulse_t, 3 * FRAME + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
